// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit sitting between the EX/MEM and MEM/WB
// pipeline registers. Issues one data-memory access at a time on a registered req/ack
// bus, stalls the pipeline until the access completes, and formats load data
// (byte/half/word, signed or unsigned) into ReadDataM for mem_wb_reg.
//
// Configuration macro: MEM_STAGE_LSU_MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses are trapped: no bus request, MisalignM pulse
//   undefined - address low bits are truncated to natural alignment, MisalignM tied to 0
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   ALUResultM, WriteDataM     byte address and store data from EX/MEM
//   MemWriteM, MemReadM        store / load request (mutually exclusive)
//   funct3M                    access size and sign
//   ReadDataM                  formatted load data (valid in DONE)
//   StallM                     pipeline freeze
//   BusErrM, MisalignM         one-cycle error pulses in DONE
//   dmem_req/we/addr/wdata/be  registered data-memory request
//   dmem_rdata, dmem_ack       data-memory response (sampled only in BUSY)

module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [2:0]  funct3M,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        BusErrM,
    output logic        MisalignM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    // Access size encoding
    localparam logic [1:0] SzByte = 2'd0;
    localparam logic [1:0] SzHalf = 2'd1;
    localparam logic [1:0] SzWord = 2'd2;

    state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        buserr_q, buserr_d;
    logic        misalign_q, misalign_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic        load_q, load_d;

    logic        access;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  eff_off;
    logic        misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    assign access = MemReadM | MemWriteM;

    // Decode size; reserved encodings 011/110/111 fall through to word.
    always_comb begin
        size = SzWord;
        uns  = 1'b0;
        unique case (funct3M)
            3'b000:  size = SzByte;
            3'b001:  size = SzHalf;
            3'b100: begin
                size = SzByte;
                uns  = 1'b1;
            end
            3'b101: begin
                size = SzHalf;
                uns  = 1'b1;
            end
            default: size = SzWord;
        endcase
    end

    // Offset after natural-alignment truncation (halfword drops bit 0, word drops both).
    always_comb begin
        eff_off = ALUResultM[1:0];
        if (size == SzHalf) begin
            eff_off = {ALUResultM[1], 1'b0};
        end else if (size == SzWord) begin
            eff_off = 2'b00;
        end
    end

`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
    assign misaligned = ((size == SzHalf) && ALUResultM[0]) ||
                        ((size == SzWord) && (ALUResultM[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Store lane placement
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = WriteDataM;
        if (size == SzByte) begin
            st_be    = 4'b0001 << eff_off;
            st_wdata = {4{WriteDataM[7:0]}};
        end else if (size == SzHalf) begin
            st_be    = eff_off[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{WriteDataM[15:0]}};
        end
    end

    // Load lane selection and extension, using the attributes captured at issue
    always_comb begin
        unique case (off_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (size_q == SzByte) begin
            ld_fmt = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        end else if (size_q == SzHalf) begin
            ld_fmt = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        end else begin
            ld_fmt = dmem_rdata;
        end
    end

    // Next-state and outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        buserr_d   = 1'b0;
        misalign_d = 1'b0;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        load_d     = load_q;
        StallM     = 1'b0;

        unique case (state_q)
            StIdle: begin
                StallM = access;
                if (access) begin
                    if (misaligned) begin
                        // Trapped: skip the bus entirely
                        state_d    = StDone;
                        misalign_d = 1'b1;
                        rdata_d    = 32'h0;
                    end else begin
                        state_d = StBusy;
                        req_d   = 1'b1;
                        we_d    = MemWriteM;
                        addr_d  = {ALUResultM[31:2], 2'b00};
                        wdata_d = MemWriteM ? st_wdata : 32'h0;
                        be_d    = MemWriteM ? st_be : 4'b1111;
                        size_d  = size;
                        uns_d   = uns;
                        off_d   = eff_off;
                        load_d  = MemReadM;
                        cnt_d   = '0;
                    end
                end
            end
            StBusy: begin
                StallM = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                // Ack takes priority over a coincident timeout
                if (dmem_ack) begin
                    rdata_d = load_q ? ld_fmt : 32'h0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = StDone;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d  = 32'h0;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    buserr_d = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                StallM  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rdata_q    <= 32'h0;
            buserr_q   <= 1'b0;
            misalign_q <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            size_q     <= SzWord;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            buserr_q   <= buserr_d;
            misalign_q <= misalign_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            load_q     <= load_d;
        end
    end

    assign ReadDataM  = rdata_q;
    assign BusErrM    = buserr_q;
    assign MisalignM  = misalign_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu with an expectation queue and a behavioural
// memory responder that acks after a per-access programmable number of BUSY cycles.

module tb_mem_stage_lsu;

    localparam int unsigned TO = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        MemWriteM;
    logic        MemReadM;
    logic [2:0]  funct3M;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        BusErrM;
    logic        MisalignM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int vectors;
    int miscompares;

    typedef struct {
        logic [31:0] rdata;
        logic        buserr;
        logic        mis;
        int          stalls;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic        chk_st;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] memwb;

    mem_stage_lsu #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .MemWriteM (MemWriteM),
        .MemReadM  (MemReadM),
        .funct3M   (funct3M),
        .ReadDataM (ReadDataM),
        .StallM    (StallM),
        .BusErrM   (BusErrM),
        .MisalignM (MisalignM),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_be   (dmem_be),
        .dmem_rdata(dmem_rdata),
        .dmem_ack  (dmem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for mem_wb_reg: captures whenever the pipeline is not stalled
    always_ff @(posedge clk) begin
        if (!StallM) memwb <= ReadDataM;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one access at posedge+1 and run it to DONE. ack_at = BUSY-cycle index of ack, -1 = never.
    task automatic run(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int ack_at,
                       input logic [31:0] rdata, input exp_t e);
        int    busy;
        int    stalls;
        bit    seen_req;
        bit    done;
        exp_t  x;
        busy     = 0;
        stalls   = 0;
        seen_req = 0;
        done     = 0;
        exp_q.push_back(e);
        MemReadM   = rd;
        MemWriteM  = wr;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (!StallM) begin
                done = 1;
            end else begin
                stalls++;
                chk({tag, ".buserr_early"}, {31'h0, BusErrM}, 32'h0);
                chk({tag, ".mis_early"}, {31'h0, MisalignM}, 32'h0);
                if (dmem_req) begin
                    if (!seen_req) begin
                        seen_req = 1;
                        chk({tag, ".we"}, {31'h0, dmem_we}, {31'h0, e.we});
                        chk({tag, ".addr"}, dmem_addr, e.addr);
                        if (e.chk_st) begin
                            chk({tag, ".be"}, {28'h0, dmem_be}, {28'h0, e.be});
                            chk({tag, ".wdata"}, dmem_wdata, e.wdata);
                        end
                    end
                    if (busy == ack_at) begin
                        dmem_ack   = 1'b1;
                        dmem_rdata = rdata;
                    end
                    busy++;
                end
                @(posedge clk);
                #1;
                dmem_ack   = 1'b0;
                dmem_rdata = 32'h5A5A_5A5A;
            end
        end
        x = exp_q.pop_front();
        if (!done) begin
            vectors++;
            miscompares++;
            $error("FAIL %s.bound: observed no completion expected DONE within budget", tag);
        end else begin
            chk({tag, ".rdata"}, ReadDataM, x.rdata);
            chk({tag, ".buserr"}, {31'h0, BusErrM}, {31'h0, x.buserr});
            chk({tag, ".mis"}, {31'h0, MisalignM}, {31'h0, x.mis});
            chk({tag, ".stalls"}, stalls, x.stalls);
            chk({tag, ".req_seen"}, {31'h0, seen_req}, {31'h0, x.req});
            chk({tag, ".req_done"}, {31'h0, dmem_req}, 32'h0);
            @(posedge clk);
            #1;
            chk({tag, ".memwb"}, memwb, x.rdata);
        end
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
    endtask

    function automatic exp_t ld(input logic [31:0] rdata, input logic [31:0] addr,
                                input int stalls, input logic buserr);
        exp_t e;
        e = '{rdata: rdata, buserr: buserr, mis: 1'b0, stalls: stalls, req: 1'b1, we: 1'b0,
              addr: addr, chk_st: 1'b0, wdata: 32'h0, be: 4'h0};
        return e;
    endfunction

    function automatic exp_t st(input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input int stalls);
        exp_t e;
        e = '{rdata: 32'h0, buserr: 1'b0, mis: 1'b0, stalls: stalls, req: 1'b1, we: 1'b1,
              addr: addr, chk_st: 1'b1, wdata: wdata, be: be};
        return e;
    endfunction

    initial begin
        exp_t m;
        vectors     = 0;
        miscompares = 0;
        rst_n      = 1'b0;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        MemWriteM  = 1'b0;
        MemReadM   = 1'b0;
        funct3M    = 3'b010;
        dmem_rdata = 32'h5A5A_5A5A;
        dmem_ack   = 1'b0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst.req", {31'h0, dmem_req}, 32'h0);
        chk("rst.we", {31'h0, dmem_we}, 32'h0);
        chk("rst.addr", dmem_addr, 32'h0);
        chk("rst.be", {28'h0, dmem_be}, 32'h0);
        chk("rst.rdata", ReadDataM, 32'h0);
        chk("rst.stall", {31'h0, StallM}, 32'h0);
        chk("rst.buserr", {31'h0, BusErrM}, 32'h0);

        @(posedge clk);
        #1;
        run("lw", 1, 0, 3'b010, 32'h100, 0, 0, 32'hDEAD_BEEF, ld(32'hDEAD_BEEF, 32'h100, 2, 0));
        run("lb", 1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF_1122, ld(32'hFFFF_FF80, 32'h100, 2, 0));
        run("lbu", 1, 0, 3'b100, 32'h103, 0, 0, 32'h80FF_1122, ld(32'h0000_0080, 32'h100, 2, 0));
        run("lhu", 1, 0, 3'b101, 32'h102, 0, 0, 32'h80FF_1122, ld(32'h0000_80FF, 32'h100, 2, 0));
        // Timeout: TO BUSY cycles plus the IDLE cycle
        run("tmo", 1, 0, 3'b010, 32'h500, 0, -1, 32'h0, ld(32'h0, 32'h500, TO + 1, 1));
        run("lh", 1, 0, 3'b001, 32'h102, 0, 1, 32'h80FF_1122, ld(32'hFFFF_80FF, 32'h100, 3, 0));
        run("lb1", 1, 0, 3'b000, 32'h101, 0, 0, 32'h80FF_1122, ld(32'h0000_0011, 32'h100, 2, 0));
        // Ack on the last BUSY cycle collides with the timeout and must win
        run("coin", 1, 0, 3'b010, 32'h504, 0, TO - 1, 32'h1234_5678,
            ld(32'h1234_5678, 32'h504, TO + 1, 0));
        run("sh", 0, 1, 3'b001, 32'h206, 32'h1234_ABCD, 4, 32'h0,
            st(32'h204, 4'b1100, 32'hABCD_ABCD, 6));
        run("sb", 0, 1, 3'b000, 32'h301, 32'h0000_00A5, 0, 32'h0,
            st(32'h300, 4'b0010, 32'hA5A5_A5A5, 2));
        run("sw", 0, 1, 3'b010, 32'h400, 32'hCAFE_F00D, 2, 32'h0,
            st(32'h400, 4'b1111, 32'hCAFE_F00D, 4));
        run("f3_011", 1, 0, 3'b011, 32'h600, 0, 0, 32'h8765_4321,
            ld(32'h8765_4321, 32'h600, 2, 0));
`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
        m = ld(32'h0, 32'h0, 1, 0);
        m.mis = 1'b1;
        m.req = 1'b0;
        run("mis_lw", 1, 0, 3'b010, 32'h101, 0, 0, 32'h0BAD_F00D, m);
`else
        m = ld(32'h0BAD_F00D, 32'h100, 2, 0);
        run("mis_lw", 1, 0, 3'b010, 32'h101, 0, 0, 32'h0BAD_F00D, m);
`endif

        // Leave a nonzero ReadDataM behind so the reset clear is observable
        run("pre_rst", 1, 0, 3'b010, 32'h700, 0, 0, 32'h7777_7777,
            ld(32'h7777_7777, 32'h700, 2, 0));
        MemReadM   = 1'b1;
        funct3M    = 3'b010;
        ALUResultM = 32'h704;
        repeat (3) @(posedge clk);
        #3;
        chk("mid.req_busy", {31'h0, dmem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid.req_rst", {31'h0, dmem_req}, 32'h0);
        MemReadM = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid.rdata", ReadDataM, 32'h0);
        chk("mid.addr", dmem_addr, 32'h0);
        chk("mid.stall", {31'h0, StallM}, 32'h0);
        chk("mid.buserr", {31'h0, BusErrM}, 32'h0);
        @(posedge clk);
        #1;
        run("post_rst", 1, 0, 3'b010, 32'h800, 0, 0, 32'h0101_0202,
            ld(32'h0101_0202, 32'h800, 2, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
